// File: rtl/fma_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package  : fma_seq_pkg
// Purpose  : Shared types and constants for the dot-product FMA sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fma_seq_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NTERMS  = 9;
  localparam int DEF_FMA_LAT = 3;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  // Width needed to index n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int SLOT_IDX_W = idx_width(DEF_NTERMS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_OUT     = 3'd4
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/fma_operand_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fma_operand_buffer
// Purpose  : NTERMS a/b operand slots with indexed write, bulk clear to +0.0
//            and packed bus outputs (slot k at bits [k*WIDTH +: WIDTH]).
// Revision : 1.0 - initial release
// ============================================================================
module fma_operand_buffer
  import fma_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NTERMS = DEF_NTERMS,
  parameter int IDX_W  = SLOT_IDX_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [WIDTH-1:0]        wr_a,
  input  logic [WIDTH-1:0]        wr_b,
  output logic [NTERMS*WIDTH-1:0] slot_a,
  output logic [NTERMS*WIDTH-1:0] slot_b
);

  logic [NTERMS*WIDTH-1:0] slot_a_q, slot_a_d;
  logic [NTERMS*WIDTH-1:0] slot_b_q, slot_b_d;

  // Clear has priority so a finished group never leaks into the next one.
  always_comb begin
    slot_a_d = slot_a_q;
    slot_b_d = slot_b_q;
    if (clr) begin
      for (int k = 0; k < NTERMS; k++) begin
        slot_a_d[k*WIDTH +: WIDTH] = WIDTH'(FP_ZERO);
        slot_b_d[k*WIDTH +: WIDTH] = WIDTH'(FP_ZERO);
      end
    end else if (wr_en) begin
      for (int k = 0; k < NTERMS; k++) begin
        if (wr_idx == IDX_W'(k)) begin
          slot_a_d[k*WIDTH +: WIDTH] = wr_a;
          slot_b_d[k*WIDTH +: WIDTH] = wr_b;
        end
      end
    end
  end

  // Slot storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_a_q <= '0;
      slot_b_q <= '0;
    end else begin
      slot_a_q <= slot_a_d;
      slot_b_q <= slot_b_d;
    end
  end

  assign slot_a = slot_a_q;
  assign slot_b = slot_b_q;

endmodule
`default_nettype wire

// File: rtl/fma_dot_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fma_dot_sequencer
// Purpose  : Packs a valid/ready stream of (a,b) pairs into NTERMS-wide groups,
//            issues them to the dot-product FMA with the running accumulator
//            as C, and returns the final dot product on a valid/ready output.
// Options  : FMA_SEQ_PERF_EN - adds perf_clr input and saturating
//            perf_groups / perf_stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module fma_dot_sequencer
  import fma_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NTERMS  = DEF_NTERMS,
  parameter int FMA_LAT = DEF_FMA_LAT
`ifdef FMA_SEQ_PERF_EN
  ,
  parameter int CNT_W   = 32
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_a,
  input  logic [WIDTH-1:0]        in_b,
  input  logic                    in_last,
  input  logic [WIDTH-1:0]        in_c_init,
  output logic [NTERMS*WIDTH-1:0] fma_a,
  output logic [NTERMS*WIDTH-1:0] fma_b,
  output logic [WIDTH-1:0]        fma_c,
  output logic [1:0]              fma_rnd,
  input  logic [WIDTH-1:0]        fma_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data
`ifdef FMA_SEQ_PERF_EN
  ,
  input  logic                    perf_clr,
  output logic [CNT_W-1:0]        perf_groups,
  output logic [CNT_W-1:0]        perf_stall
`endif
);

  localparam int IDX_W  = idx_width(NTERMS);
  localparam int WAIT_W = idx_width(FMA_LAT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NTERMS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LD  = WAIT_W'(FMA_LAT);

  seq_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    first_q, first_d;
  logic                    last_grp_q, last_grp_d;
  logic [WAIT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]        acc_q, acc_d;
  logic [NTERMS*WIDTH-1:0] fma_a_q, fma_a_d;
  logic [NTERMS*WIDTH-1:0] fma_b_q, fma_b_d;
  logic [WIDTH-1:0]        fma_c_q, fma_c_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;

  logic                    buf_clr;
  logic                    buf_wr;
  logic [NTERMS*WIDTH-1:0] slot_a;
  logic [NTERMS*WIDTH-1:0] slot_b;

  fma_operand_buffer #(
    .WIDTH  (WIDTH),
    .NTERMS (NTERMS),
    .IDX_W  (IDX_W)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .clr    (buf_clr),
    .wr_en  (buf_wr),
    .wr_idx (idx_q),
    .wr_a   (in_a),
    .wr_b   (in_b),
    .slot_a (slot_a),
    .slot_b (slot_b)
  );

  // Next-state, datapath updates and slot-buffer control.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    first_d    = first_q;
    last_grp_d = last_grp_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    fma_a_d    = fma_a_q;
    fma_b_d    = fma_b_q;
    fma_c_d    = fma_c_q;
    out_data_d = out_data_q;
    buf_clr    = 1'b0;
    buf_wr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        buf_clr = 1'b1;
        state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (in_valid) begin
          buf_wr = 1'b1;
          idx_d  = idx_q + 1'b1;
          if (first_q) begin
            acc_d   = in_c_init;
            first_d = 1'b0;
          end
          if ((idx_q == LAST_IDX) || in_last) begin
            last_grp_d = in_last;
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        fma_a_d = slot_a;
        fma_b_d = slot_b;
        fma_c_d = acc_q;
        cnt_d   = WAIT_LD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          // Result of this group becomes C for the next one.
          acc_d   = fma_result;
          idx_d   = '0;
          buf_clr = 1'b1;
          if (last_grp_q) begin
            out_data_d = fma_result;
            state_d    = ST_OUT;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          first_d = 1'b1;
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      first_q    <= 1'b1;
      last_grp_q <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      fma_a_q    <= '0;
      fma_b_q    <= '0;
      fma_c_q    <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      first_q    <= first_d;
      last_grp_q <= last_grp_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      fma_a_q    <= fma_a_d;
      fma_b_q    <= fma_b_d;
      fma_c_q    <= fma_c_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = (state_q == ST_COLLECT);
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = out_data_q;
  assign fma_a     = fma_a_q;
  assign fma_b     = fma_b_q;
  assign fma_c     = fma_c_q;
  assign fma_rnd   = 2'b00;

`ifdef FMA_SEQ_PERF_EN
  logic [CNT_W-1:0] perf_groups_q, perf_groups_d;
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d;

  // Saturating issue and stall counters with synchronous clear.
  always_comb begin
    perf_groups_d = perf_groups_q;
    perf_stall_d  = perf_stall_q;
    if (perf_clr) begin
      perf_groups_d = '0;
      perf_stall_d  = '0;
    end else begin
      if ((state_q == ST_ISSUE) && (perf_groups_q != '1))
        perf_groups_d = perf_groups_q + 1'b1;
      if (((state_q == ST_WAIT) || ((state_q == ST_OUT) && !out_ready)) &&
          (perf_stall_q != '1))
        perf_stall_d = perf_stall_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_groups_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_groups_q <= perf_groups_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_groups = perf_groups_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fma_dot_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fma_dot_sequencer
// Purpose  : Directed self-checking bench for fma_dot_sequencer with a
//            behavioural FMA_LAT-stage dot-product FMA in the loop.
// Options  : FMA_SEQ_PERF_EN - also exercises the perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fma_dot_sequencer;

  localparam int W   = 32;
  localparam int NT  = 9;
  localparam int LAT = 3;

  localparam logic [31:0] F_ZERO  = 32'h0000_0000;
  localparam logic [31:0] F_ONE   = 32'h3F80_0000;
  localparam logic [31:0] F_TWO   = 32'h4000_0000;
  localparam logic [31:0] F_THREE = 32'h4040_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_a;
  logic [W-1:0]    in_b;
  logic            in_last;
  logic [W-1:0]    in_c_init;
  logic [NT*W-1:0] fma_a;
  logic [NT*W-1:0] fma_b;
  logic [W-1:0]    fma_c;
  logic [1:0]      fma_rnd;
  logic [W-1:0]    fma_result;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
`ifdef FMA_SEQ_PERF_EN
  logic            perf_clr;
  logic [31:0]     perf_groups;
  logic [31:0]     perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int issue_cyc;
  int out_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fma_dot_sequencer #(
    .WIDTH   (W),
    .NTERMS  (NT),
    .FMA_LAT (LAT)
`ifdef FMA_SEQ_PERF_EN
    ,
    .CNT_W   (32)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_last    (in_last),
    .in_c_init  (in_c_init),
    .fma_a      (fma_a),
    .fma_b      (fma_b),
    .fma_c      (fma_c),
    .fma_rnd    (fma_rnd),
    .fma_result (fma_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef FMA_SEQ_PERF_EN
    ,
    .perf_clr    (perf_clr),
    .perf_groups (perf_groups),
    .perf_stall  (perf_stall)
`endif
  );

  // ---------------- behavioural FMA (exact for the small values used) -------
  function automatic real fp2r(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:0] == 31'h0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2fp(input real v);
    logic        s;
    int          e;
    real         m;
    logic [22:0] f;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    f = 23'(longint'((m - 1.0) * 8388608.0));
    return {s, 8'(e), f};
  endfunction

  function automatic logic [31:0] fma_model(input logic [NT*W-1:0] a,
                                            input logic [NT*W-1:0] b,
                                            input logic [W-1:0] c);
    real acc;
    acc = fp2r(c);
    for (int k = 0; k < NT; k++)
      acc = acc + fp2r(a[k*W +: W]) * fp2r(b[k*W +: W]);
    return r2fp(acc);
  endfunction

  logic [W-1:0] pipe [LAT];
  initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
  always @(posedge clk) begin
    pipe[0] <= fma_model(fma_a, fma_b, fma_c);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign fma_result = pipe[LAT-1];

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [NT*W-1:0] obs,
                          input logic [NT*W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NT*W-1:0] make_bus(input logic [W-1:0] v, input int terms);
    logic [NT*W-1:0] bus;
    bus = '0;
    for (int k = 0; k < NT; k++)
      if (k < terms) bus[k*W +: W] = v;
    return bus;
  endfunction

  // One input beat: present at negedge, hold until accepted on a rising edge.
  task automatic feed_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic last);
    int guard;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_c_init = c; in_last = last;
    guard = 0;
    while (!in_ready && guard < 64) begin @(negedge clk); guard++; end
    if (guard >= 64) check_eq("in_handshake_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Full vector of n identical pairs; checks the FMA operands at each issue.
  task automatic send_vec(input string tag, input int n, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] c,
                          input logic [W-1:0] exp_c0, input logic [W-1:0] exp_c1);
    int g;
    int terms;
    g = 0;
    for (int i = 0; i < n; i++) begin
      feed_beat(a, b, c, (i == n - 1));
      if ((i % NT == NT - 1) || (i == n - 1)) begin
        @(posedge clk);
        @(negedge clk);
        issue_cyc = cyc;
        terms = (n - g * NT < NT) ? (n - g * NT) : NT;
        check_eq({tag, "_fma_c"}, fma_c, (g == 0) ? exp_c0 : exp_c1);
        check_eq({tag, "_fma_a"}, fma_a, make_bus(a, terms));
        check_eq({tag, "_fma_b"}, fma_b, make_bus(b, terms));
        g++;
      end
    end
  endtask

  // Wait for the result with out_ready high; OUT must last exactly one cycle.
  task automatic get_result(input string tag, input logic [W-1:0] exp);
    int guard;
    guard = 0;
    while (!out_valid && guard < 64) begin @(negedge clk); guard++; end
    if (guard >= 64) check_eq({tag, "_out_timeout"}, 0, 1);
    out_cyc = cyc;
    check_eq({tag, "_out_data"}, out_data, exp);
    @(negedge clk);
    check_eq({tag, "_out_drop"}, out_valid, 0);
  endtask

  initial begin
    int guard;
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    in_c_init = '0; out_ready = 1'b1;
`ifdef FMA_SEQ_PERF_EN
    perf_clr = 1'b0;
`endif
    #3;
    check_eq("rst_in_ready",  in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data",  out_data, 0);
    check_eq("rst_fma_a",     fma_a, 0);
    check_eq("rst_fma_b",     fma_b, 0);
    check_eq("rst_fma_c",     fma_c, 0);
    check_eq("rst_fma_rnd",   fma_rnd, 0);
`ifdef FMA_SEQ_PERF_EN
    check_eq("rst_perf_groups", perf_groups, 0);
    check_eq("rst_perf_stall",  perf_stall, 0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // 9 x (1.0*2.0) + 0 = 18.0, single group
    send_vec("v9", 9, F_ONE, F_TWO, F_ZERO, F_ZERO, F_ZERO);
    get_result("v9", 32'h4190_0000);

    // 12 pairs: second group gets C = 18.0 and only 3 live slots -> 24.0
    send_vec("v12", 12, F_ONE, F_TWO, F_ZERO, F_ZERO, 32'h4190_0000);
    get_result("v12", 32'h41C0_0000);

    // Single pair 3.0*2.0 + 1.0 = 7.0; result lands FMA_LAT+1 edges after issue
    send_vec("v1", 1, F_THREE, F_TWO, F_ONE, F_ONE, F_ZERO);
    get_result("v1", 32'h40E0_0000);
    check_eq("v1_latency", 32'(out_cyc - issue_cyc), 32'(LAT + 1));

    // Back-pressure in OUT: 9 x 2.0 + 1.0 = 19.0 held for 5 cycles
    out_ready = 1'b0;
    send_vec("bp", 9, F_ONE, F_TWO, F_ONE, F_ONE, F_ZERO);
    guard = 0;
    while (!out_valid && guard < 64) begin @(negedge clk); guard++; end
    if (guard >= 64) check_eq("bp_out_timeout", 0, 1);
    in_valid = 1'b1; in_a = F_THREE; in_b = F_TWO; in_c_init = F_ZERO; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_out_data",  out_data, 32'h4198_0000);
      check_eq("bp_in_ready",  in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("bp_out_drop", out_valid, 0);
    check_eq("bp_in_ready_after", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("bp_next_fma_c", fma_c, F_ZERO);
    check_eq("bp_next_fma_a", fma_a, make_bus(F_THREE, 1));
    get_result("bp_next", 32'h40C0_0000);

    // Reset during WAIT of the first group of a 12-pair vector
    for (int i = 0; i < 9; i++) feed_beat(F_ONE, F_TWO, F_ONE, 1'b0);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("ar_in_ready",  in_ready, 0);
    check_eq("ar_out_valid", out_valid, 0);
    check_eq("ar_out_data",  out_data, 0);
    check_eq("ar_fma_a",     fma_a, 0);
    check_eq("ar_fma_b",     fma_b, 0);
    check_eq("ar_fma_c",     fma_c, 0);
    @(negedge clk);
    rst = 1'b1;
    send_vec("ar9", 9, F_ONE, F_TWO, F_ZERO, F_ZERO, F_ZERO);
    get_result("ar9", 32'h4190_0000);

`ifdef FMA_SEQ_PERF_EN
    @(negedge clk);
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    check_eq("perf_clr_groups", perf_groups, 0);
    check_eq("perf_clr_stall",  perf_stall, 0);
    send_vec("pf", 12, F_ONE, F_TWO, F_ZERO, F_ZERO, 32'h4190_0000);
    get_result("pf", 32'h41C0_0000);
    check_eq("perf_groups", perf_groups, 2);
    check_eq("perf_stall",  perf_stall, 32'(2 * LAT + 2));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
